fetch_unit: RTL and testbench

Instruction fetch front end for the pipelined MIPS core. It owns the fetch PC, issues word requests to instruction memory over a request/acknowledge interface, and buffers returned instructions with their PCs in a small FIFO. It hands them to the decode stage through a valid/ready handshake. Branch and jump redirects arrive from the execute stage and flush everything younger than the redirect.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 54 +++++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: fetch state encoding,
// default reset vector, instruction width and the fetch queue entry layout.
package mips_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    DISCARD = 2'd2
  } fetchState_t;

  // One buffered fetch: the PC it came from and the word memory returned.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instruction;
  } fetchEntry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of {pc, instruction} entries between fetch and decode.
// Pointers wrap naturally; count carries one extra bit so full is exact.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fetchEntry_t wrEntry,
  output fetchEntry_t headEntry,
  output logic [PW:0] count,
  output logic        full,
  output logic        empty
);

  fetchEntry_t   mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          doPush;
  logic          doPop;

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign doPush    = push && !full && !flush;
  assign doPop     = pop && !empty && !flush;
  assign headEntry = mem[head];

  // Pointer and occupancy bookkeeping; flush empties without touching storage.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (doPush) tail <= tail + PW'(1);
      if (doPop)  head <= head + PW'(1);
      count <= count + {{PW{1'b0}}, doPush} - {{PW{1'b0}}, doPop};
    end
  end

  // Entry storage; no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (doPush) mem[tail] <= wrEntry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues word requests to
// instruction memory, buffers returns and hands them to decode. Redirects
// from execute flush the queue; a redirect that lands on an un-acked request
// parks the target until the stale request drains.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rstN,
  output logic               imReq,
  output logic [31:0]        imAddress,
  input  logic               imAck,
  input  logic [INSTR_W-1:0] imInstruction,
  input  logic               redirect,
  input  logic [31:0]        redirectTarget,
  output logic               outValid,
  input  logic               outReady,
  output logic [INSTR_W-1:0] outInstruction,
  output logic [31:0]        outPc,
  output logic [31:0]        outPcAdd4
);

  localparam int unsigned PW = $clog2(QUEUE_DEPTH);

  fetchState_t state;
  fetchState_t stateNext;
  logic [31:0] fetchPc;
  logic [31:0] pendingPc;
  logic        pushEn;
  logic        popEn;
  fetchEntry_t wrEntry;
  fetchEntry_t headEntry;
  logic [PW:0] qCount;
  logic        qFull;
  logic        qEmpty;

  // Request side only ever depends on registered state, so it is stable
  // until acked: in RUN the count can only drop while a request waits.
  always_comb begin
    imReq     = 1'b0;
    imAddress = fetchPc;
    case (state)
      RUN:     imReq = !qFull;
      DISCARD: imReq = 1'b1;
      default: imReq = 1'b0;
    endcase
  end

  assign pushEn          = (state == RUN) && imReq && imAck && !redirect;
  assign popEn           = outValid && outReady && !redirect;
  assign wrEntry.pc          = fetchPc;
  assign wrEntry.instruction = imInstruction;

  fetch_queue #(.DEPTH(QUEUE_DEPTH), .PW(PW)) uQueue (
    .clk       (clk),
    .rstN      (rstN),
    .push      (pushEn),
    .pop       (popEn),
    .flush     (redirect),
    .wrEntry   (wrEntry),
    .headEntry (headEntry),
    .count     (qCount),
    .full      (qFull),
    .empty     (qEmpty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rstN) state <= BOOT;
    else       state <= stateNext;
  end

  // Next state: a redirect onto an outstanding request must wait it out.
  always_comb begin
    stateNext = state;
    case (state)
      BOOT:    stateNext = RUN;
      RUN:     if (redirect && imReq && !imAck) stateNext = DISCARD;
      DISCARD: if (imAck) stateNext = RUN;
      default: stateNext = BOOT;
    endcase
  end

  // Fetch PC and parked redirect target; redirect outranks everything.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      fetchPc   <= RESET_PC;
      pendingPc <= RESET_PC;
    end else if (redirect) begin
      if (imReq && !imAck) pendingPc <= redirectTarget;
      else                 fetchPc   <= redirectTarget;
    end else if ((state == DISCARD) && imAck) begin
      fetchPc <= pendingPc;
    end else if (pushEn) begin
      fetchPc <= fetchPc + 32'd4;
    end
  end

  // Decode-facing outputs come straight off the queue head, zeroed when empty.
  always_comb begin
    outValid       = !qEmpty;
    outInstruction = '0;
    outPc          = '0;
    outPcAdd4      = '0;
    if (!qEmpty) begin
      outInstruction = headEntry.instruction;
      outPc          = headEntry.pc;
      outPcAdd4      = headEntry.pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: the bench plays instruction memory with
// variable ack latency and keeps an abstract model (expected fetch address,
// a queue of fetched PCs, a stale-request flag) to predict every output.
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstN;
  logic        imReq;
  logic [31:0] imAddress;
  logic        imAck;
  logic [31:0] imInstruction;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInstruction;
  logic [31:0] outPc;
  logic [31:0] outPcAdd4;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rstN           (rstN),
    .imReq          (imReq),
    .imAddress      (imAddress),
    .imAck          (imAck),
    .imInstruction  (imInstruction),
    .redirect       (redirect),
    .redirectTarget (redirectTarget),
    .outValid       (outValid),
    .outReady       (outReady),
    .outInstruction (outInstruction),
    .outPc          (outPc),
    .outPcAdd4      (outPcAdd4)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory contents: a fixed scramble of the address, so data proves the PC.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  // Reference model state.
  logic [31:0] mQ[$];
  logic [31:0] mPc;
  logic [31:0] mPend;
  bit          mBoot;
  bit          mStale;

  // Memory model state.
  bit          memBusy;
  int          memWait;
  int          minLat;
  int          maxLat;
  bit          prevStall;
  logic [31:0] prevAddr;

  task automatic modelReset();
    mQ.delete();
    mPc       = RPC;
    mPend     = '0;
    mBoot     = 1'b1;
    mStale    = 1'b0;
    memBusy   = 1'b0;
    memWait   = 0;
    prevStall = 1'b0;
  endtask

  task automatic checkResetOutputs();
    chk("rst.imReq",          imReq,          32'd0);
    chk("rst.imAddress",      imAddress,      RPC);
    chk("rst.outValid",       outValid,       32'd0);
    chk("rst.outInstruction", outInstruction, 32'd0);
    chk("rst.outPc",          outPc,          32'd0);
    chk("rst.outPcAdd4",      outPcAdd4,      32'd0);
  endtask

  // One clock: check outputs at the negedge, act as memory, drive inputs,
  // advance the model for the coming rising edge.
  task automatic cycle(input bit rd, input logic [31:0] tgt, input bit rdy);
    bit          expReq;
    bit          ack;
    logic [31:0] h;
    expReq = mBoot ? 1'b0 : (mStale ? 1'b1 : (mQ.size() < DEPTH));
    chk("imReq",     imReq,     expReq);
    chk("imAddress", imAddress, mPc);
    if (prevStall) begin
      chk("hold.imReq",     imReq,     32'd1);
      chk("hold.imAddress", imAddress, prevAddr);
    end
    h = (mQ.size() > 0) ? mQ[0] : 32'd0;
    chk("outValid",       outValid,       (mQ.size() > 0));
    chk("outPc",          outPc,          h);
    chk("outInstruction", outInstruction, (mQ.size() > 0) ? memWord(h) : 32'd0);
    chk("outPcAdd4",      outPcAdd4,      (mQ.size() > 0) ? h + 32'd4 : 32'd0);

    ack = 1'b0;
    if (imReq) begin
      if (!memBusy) begin
        memBusy = 1'b1;
        memWait = $urandom_range(maxLat, minLat);
      end
      if (memWait == 0) begin
        ack     = 1'b1;
        memBusy = 1'b0;
      end else begin
        memWait--;
      end
    end
    imAck          = ack;
    imInstruction  = ack ? memWord(imAddress) : $urandom;
    redirect       = rd;
    redirectTarget = tgt;
    outReady       = rdy;
    prevStall      = imReq && !ack;
    prevAddr       = imAddress;

    if (rd) begin
      mQ.delete();
      if (!expReq || ack) begin
        mPc    = tgt;
        mStale = 1'b0;
      end else begin
        mPend  = tgt;
        mStale = 1'b1;
      end
    end else begin
      if (mQ.size() > 0 && rdy) void'(mQ.pop_front());
      if (mStale) begin
        if (ack) begin
          mPc    = mPend;
          mStale = 1'b0;
        end
      end else if (expReq && ack) begin
        mQ.push_back(mPc);
        mPc = mPc + 32'd4;
      end
    end
    mBoot = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rstN           = 1'b0;
    imAck          = 1'b0;
    imInstruction  = '0;
    redirect       = 1'b0;
    redirectTarget = '0;
    outReady       = 1'b0;
    minLat         = 0;
    maxLat         = 0;
    repeat (2) @(negedge clk);
    checkResetOutputs();
    modelReset();
    rstN = 1'b1;

    // Zero-latency memory, decode always ready: streaming from RESET_PC.
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1);

    // Decode stalls until the queue fills, then drains in order.
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b0);
    chk("full.imReq", imReq, 32'd0);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);

    // Redirect with a partly full queue and a same-cycle ack.
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 32'h0000_0100, 1'b1);
    chk("redir.outValid", outValid, 32'd0);
    chk("redir.imAddress", imAddress, 32'h0000_0100);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

    // Fixed 3-cycle memory: redirects land on an outstanding request.
    minLat = 3;
    maxLat = 3;
    for (int i = 0; i < 20 && !prevStall; i++) cycle(1'b0, '0, 1'b1);
    chk("discard.stalled", prevStall, 32'd1);
    cycle(1'b1, 32'h0000_0200, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 20 && !prevStall; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 32'h0000_0300, 1'b1);
    cycle(1'b1, 32'h0000_0400, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);

    // Address wrap at the top of memory.
    minLat = 0;
    maxLat = 0;
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);

    // Randomized traffic with varying memory latency and decode back-pressure.
    for (int blk = 0; blk < 20; blk++) begin
      minLat = 0;
      maxLat = $urandom_range(3, 0);
      for (int i = 0; i < 80; i++) begin
        logic [31:0] t;
        t = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | {$urandom_range(3, 0), 2'b00})
                                        : {$urandom, 2'b00} & 32'h0000_FFFC;
        cycle(($urandom_range(9, 0) == 0), t, ($urandom_range(3, 0) != 0));
      end
    end

    // Reset in the middle of traffic abandons any request.
    maxLat = 3;
    for (int i = 0; i < 20 && !prevStall; i++) cycle(1'b0, '0, 1'b0);
    rstN     = 1'b0;
    imAck    = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    checkResetOutputs();
    modelReset();
    rstN = 1'b1;
    for (int i = 0; i < 40; i++) cycle(1'b0, '0, ($urandom_range(1, 0) == 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
